mem_port_arbiter: RTL and testbench

- Sits inside amadeus_top, directly upstream of the unified memory port.
- Has three clients: ifmap buffer read, weight buffer read and compressor write. It multiplexes them onto the single memory interface (mem_addr, mem_write_data, mem_write_valid, mem_read_valid).
- Routes in-order read returns (mem_data, mem_valid) back to the read client that issued each request.
- Arbitration is round-robin. Outstanding reads are tracked in a client-ID FIFO.

---
 rtl/mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter folding two read clients (ifmap, weight)
//                and one write client (compressor) onto a single memory port.
//                In-order read returns are steered back to the issuing read
//                client using a small client-ID FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 ifm_req_valid,
    input  logic [ADDR_W-1:0]                    ifm_req_addr,
    output logic                                 ifm_req_ready,
    output logic                                 ifm_rsp_valid,

    input  logic                                 wgt_req_valid,
    input  logic [ADDR_W-1:0]                    wgt_req_addr,
    output logic                                 wgt_req_ready,
    output logic                                 wgt_rsp_valid,

    input  logic                                 cmp_wr_valid,
    input  logic [ADDR_W-1:0]                    cmp_wr_addr,
    input  logic [DATA_W-1:0]                    cmp_wr_data,
    output logic                                 cmp_wr_ready,

    output logic [DATA_W-1:0]                    rsp_data,

    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_write_data,
    output logic                                 mem_write_valid,
    output logic                                 mem_read_valid,
    input  logic [DATA_W-1:0]                    mem_data,
    input  logic                                 mem_valid,

    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
    output logic                                 err_unexpected_rsp
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    // FIFO pointer width is kept at least 1 so a depth-1 FIFO still elaborates.
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int c_DEPTH = 1 << c_PTR_W;

    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // Round-robin pointer encoding: the client that has first claim this cycle.
    localparam logic [1:0] c_RR_IFM = 2'd0;
    localparam logic [1:0] c_RR_WGT = 2'd1;
    localparam logic [1:0] c_RR_CMP = 2'd2;

    // Client IDs stored in the read-tag FIFO.
    localparam logic c_ID_IFM = 1'b0;
    localparam logic c_ID_WGT = 1'b1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]          r_rr_ptr;
    logic [1:0]          w_rr_ptr_nxt;

    logic                w_ifm_elig;
    logic                w_wgt_elig;
    logic                w_cmp_elig;
    logic                w_gnt_ifm;
    logic                w_gnt_wgt;
    logic                w_gnt_cmp;

    logic                r_id_mem [0:c_DEPTH-1];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_outstanding;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_push_id;
    logic                w_pop;
    logic                w_pop_id;

    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_write_data;
    logic                r_mem_write_valid;
    logic                r_mem_read_valid;

    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_ifm_rsp_valid;
    logic                r_wgt_rsp_valid;
    logic                r_err_unexpected_rsp;

    // ------------------------------------------------------------------------
    // Eligibility: reads are held off while the tag FIFO is full. The
    // registered count is used on purpose, so a same-cycle pop does not free
    // a slot until the following cycle.
    // ------------------------------------------------------------------------
    assign w_ifm_elig = ifm_req_valid && (r_outstanding < c_MAX_CNT);
    assign w_wgt_elig = wgt_req_valid && (r_outstanding < c_MAX_CNT);
    assign w_cmp_elig = cmp_wr_valid;

    // Round-robin grant selection, searching from the pointer; readys stay low in reset.
    always_comb begin
        w_gnt_ifm = 1'b0;
        w_gnt_wgt = 1'b0;
        w_gnt_cmp = 1'b0;
        if (rst_n) begin
            case (r_rr_ptr)
                c_RR_WGT: begin
                    if (w_wgt_elig)      w_gnt_wgt = 1'b1;
                    else if (w_cmp_elig) w_gnt_cmp = 1'b1;
                    else if (w_ifm_elig) w_gnt_ifm = 1'b1;
                end
                c_RR_CMP: begin
                    if (w_cmp_elig)      w_gnt_cmp = 1'b1;
                    else if (w_ifm_elig) w_gnt_ifm = 1'b1;
                    else if (w_wgt_elig) w_gnt_wgt = 1'b1;
                end
                default: begin
                    if (w_ifm_elig)      w_gnt_ifm = 1'b1;
                    else if (w_wgt_elig) w_gnt_wgt = 1'b1;
                    else if (w_cmp_elig) w_gnt_cmp = 1'b1;
                end
            endcase
        end
    end

    // Pointer advances to the client after the winner; holds when idle.
    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_gnt_ifm)      w_rr_ptr_nxt = c_RR_WGT;
        else if (w_gnt_wgt) w_rr_ptr_nxt = c_RR_CMP;
        else if (w_gnt_cmp) w_rr_ptr_nxt = c_RR_IFM;
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= c_RR_IFM;
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign ifm_req_ready = w_gnt_ifm;
    assign wgt_req_ready = w_gnt_wgt;
    assign cmp_wr_ready  = w_gnt_cmp;

    // ------------------------------------------------------------------------
    // Read-tag FIFO
    // ------------------------------------------------------------------------
    assign w_push       = w_gnt_ifm | w_gnt_wgt;
    assign w_push_id    = w_gnt_wgt ? c_ID_WGT : c_ID_IFM;
    assign w_fifo_empty = (r_outstanding == '0);
    assign w_pop        = mem_valid && !w_fifo_empty;
    assign w_pop_id     = r_id_mem[r_rd_ptr];

    // Tag storage; contents are meaningless while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id_mem[r_wr_ptr] <= w_push_id;
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign outstanding = r_outstanding;

    // ------------------------------------------------------------------------
    // Memory-side issue: one cycle after the grant. Address and write data
    // hold their last values while idle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr        <= '0;
            r_mem_write_data  <= '0;
            r_mem_read_valid  <= 1'b0;
            r_mem_write_valid <= 1'b0;
        end else begin
            r_mem_read_valid  <= w_push;
            r_mem_write_valid <= w_gnt_cmp;
            if (w_gnt_ifm) begin
                r_mem_addr <= ifm_req_addr;
            end else if (w_gnt_wgt) begin
                r_mem_addr <= wgt_req_addr;
            end else if (w_gnt_cmp) begin
                r_mem_addr       <= cmp_wr_addr;
                r_mem_write_data <= cmp_wr_data;
            end
        end
    end

    assign mem_addr        = r_mem_addr;
    assign mem_write_data  = r_mem_write_data;
    assign mem_read_valid  = r_mem_read_valid;
    assign mem_write_valid = r_mem_write_valid;

    // ------------------------------------------------------------------------
    // Response steering and the sticky unexpected-response flag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data           <= '0;
            r_ifm_rsp_valid      <= 1'b0;
            r_wgt_rsp_valid      <= 1'b0;
            r_err_unexpected_rsp <= 1'b0;
        end else begin
            if (mem_valid) begin
                r_rsp_data <= mem_data;
            end
            r_ifm_rsp_valid      <= w_pop && (w_pop_id == c_ID_IFM);
            r_wgt_rsp_valid      <= w_pop && (w_pop_id == c_ID_WGT);
            r_err_unexpected_rsp <= r_err_unexpected_rsp || (mem_valid && w_fifo_empty);
        end
    end

    assign rsp_data           = r_rsp_data;
    assign ifm_rsp_valid      = r_ifm_rsp_valid;
    assign wgt_rsp_valid      = r_wgt_rsp_valid;
    assign err_unexpected_rsp = r_err_unexpected_rsp;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed, table-driven bench for mem_port_arbiter with
//                hand-written sequences for asynchronous reset mid-flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ifm_req_valid, wgt_req_valid, cmp_wr_valid, mem_valid;
    logic [AW-1:0] ifm_req_addr, wgt_req_addr, cmp_wr_addr;
    logic [DW-1:0] cmp_wr_data, mem_data;
    logic          ifm_req_ready, wgt_req_ready, cmp_wr_ready;
    logic          ifm_rsp_valid, wgt_rsp_valid;
    logic [DW-1:0] rsp_data, mem_write_data;
    logic [AW-1:0] mem_addr;
    logic          mem_write_valid, mem_read_valid;
    logic [CW-1:0] outstanding;
    logic          err_unexpected_rsp;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (MO)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ifm_req_valid      (ifm_req_valid),
        .ifm_req_addr       (ifm_req_addr),
        .ifm_req_ready      (ifm_req_ready),
        .ifm_rsp_valid      (ifm_rsp_valid),
        .wgt_req_valid      (wgt_req_valid),
        .wgt_req_addr       (wgt_req_addr),
        .wgt_req_ready      (wgt_req_ready),
        .wgt_rsp_valid      (wgt_rsp_valid),
        .cmp_wr_valid       (cmp_wr_valid),
        .cmp_wr_addr        (cmp_wr_addr),
        .cmp_wr_data        (cmp_wr_data),
        .cmp_wr_ready       (cmp_wr_ready),
        .rsp_data           (rsp_data),
        .mem_addr           (mem_addr),
        .mem_write_data     (mem_write_data),
        .mem_write_valid    (mem_write_valid),
        .mem_read_valid     (mem_read_valid),
        .mem_data           (mem_data),
        .mem_valid          (mem_valid),
        .outstanding        (outstanding),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one cycle plus what must be seen during it.
    // Registered expectations reflect the previous clock edge.
    typedef struct {
        bit          rst;
        bit          iv;  logic [15:0] ia;
        bit          wv;  logic [15:0] wa;
        bit          cv;  logic [15:0] ca;  logic [15:0] cd;
        bit          mv;  logic [15:0] md;
        bit          e_irdy, e_wrdy, e_crdy;
        bit          e_rv, e_wv;
        bit          chk_addr; logic [15:0] e_addr;
        logic [15:0] e_wdata;
        bit          e_irsp, e_wrsp; logic [15:0] e_rdata;
        logic [2:0]  e_out;
        bit          e_err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifm_req_valid = 1'b0; ifm_req_addr = '0;
        wgt_req_valid = 1'b0; wgt_req_addr = '0;
        cmp_wr_valid  = 1'b0; cmp_wr_addr  = '0; cmp_wr_data = '0;
        mem_valid     = 1'b0; mem_data     = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_irdy"},  ifm_req_ready,      0);
        chk({tag, "_wrdy"},  wgt_req_ready,      0);
        chk({tag, "_crdy"},  cmp_wr_ready,       0);
        chk({tag, "_rv"},    mem_read_valid,     0);
        chk({tag, "_wv"},    mem_write_valid,    0);
        chk({tag, "_addr"},  mem_addr,           0);
        chk({tag, "_wdata"}, mem_write_data,     0);
        chk({tag, "_rdata"}, rsp_data,           0);
        chk({tag, "_irsp"},  ifm_rsp_valid,      0);
        chk({tag, "_wrsp"},  wgt_rsp_valid,      0);
        chk({tag, "_out"},   outstanding,        0);
        chk({tag, "_err"},   err_unexpected_rsp, 0);
    endtask

    // Reset is applied and released mid-cycle, well clear of the rising edge.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t v;
        idle_inputs();

        // rst iv  ia     wv  wa     cv  ca     cd        mv  md        ir wr cr rv wv ca  addr     wdata     is ws rdata     out  err
        // --- single ifm read, memory returns 0xDEAD
        vq.push_back('{1, 1,16'h10,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 1,0, 1,16'h10,  16'h0,    0,0,16'h0,    3'd1,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'hDEAD, 0,0,0, 0,0, 1,16'h10,  16'h0,    0,0,16'h0,    3'd1,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 1,16'h10,  16'h0,    1,0,16'hDEAD, 3'd0,0});
        // --- all three clients from reset: ifm,wgt,cmp,ifm,wgt,cmp then four returns
        vq.push_back('{1, 1,16'h100, 1,16'h200, 1,16'h300, 16'hC0DE, 0,16'h0,    1,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 1,16'h100, 1,16'h200, 1,16'h300, 16'hC0DE, 0,16'h0,    0,1,0, 1,0, 1,16'h100, 16'h0,    0,0,16'h0,    3'd1,0});
        vq.push_back('{0, 1,16'h100, 1,16'h200, 1,16'h300, 16'hC0DE, 0,16'h0,    0,0,1, 1,0, 1,16'h200, 16'h0,    0,0,16'h0,    3'd2,0});
        vq.push_back('{0, 1,16'h100, 1,16'h200, 1,16'h300, 16'hC0DE, 0,16'h0,    1,0,0, 0,1, 1,16'h300, 16'hC0DE, 0,0,16'h0,    3'd2,0});
        vq.push_back('{0, 0,16'h0,   1,16'h200, 1,16'h300, 16'hC0DE, 0,16'h0,    0,1,0, 1,0, 1,16'h100, 16'h0,    0,0,16'h0,    3'd3,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   1,16'h300, 16'hC0DE, 0,16'h0,    0,0,1, 1,0, 1,16'h200, 16'h0,    0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'h0001, 0,0,0, 0,1, 1,16'h300, 16'hC0DE, 0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'h0002, 0,0,0, 0,0, 1,16'h300, 16'h0,    1,0,16'h0001, 3'd3,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'h0003, 0,0,0, 0,0, 1,16'h300, 16'h0,    0,1,16'h0002, 3'd2,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'h0004, 0,0,0, 0,0, 1,16'h300, 16'h0,    1,0,16'h0003, 3'd1,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 1,16'h300, 16'h0,    0,1,16'h0004, 3'd0,0});
        // --- FIFO fills with ifm, write still passes, full+pop still blocks
        vq.push_back('{1, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 1,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd1,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 1,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd2,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 1,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd3,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 1,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   1,16'h50,  16'hAAAA, 0,16'h0,    0,0,1, 0,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    1,16'h5555, 0,0,0, 0,1, 1,16'h50,  16'hAAAA, 0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    1,0,0, 0,0, 1,16'h50,  16'h0,    1,0,16'h5555, 3'd3,0});
        vq.push_back('{0, 1,16'h40,  0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 1,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd4,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 1,16'h40,  16'h0,    0,0,16'h0,    3'd4,0});
        // --- unexpected response sets a sticky error, no rsp_valid
        vq.push_back('{1, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    1,16'h9999, 0,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,1});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,1});
        // --- write-only traffic
        vq.push_back('{1, 0,16'h0,   0,16'h0,   1,16'h20,  16'h1234, 0,16'h0,    0,0,1, 0,0, 0,16'h0,   16'h0,    0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,1, 1,16'h20,  16'h1234, 0,0,16'h0,    3'd0,0});
        vq.push_back('{0, 0,16'h0,   0,16'h0,   0,16'h0,   16'h0,    0,16'h0,    0,0,0, 0,0, 1,16'h20,  16'h0,    0,0,16'h0,    3'd0,0});

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            if (v.rst) do_reset();
            ifm_req_valid = v.iv; ifm_req_addr = v.ia;
            wgt_req_valid = v.wv; wgt_req_addr = v.wa;
            cmp_wr_valid  = v.cv; cmp_wr_addr  = v.ca; cmp_wr_data = v.cd;
            mem_valid     = v.mv; mem_data     = v.md;
            #1;
            chk($sformatf("v%0d_irdy", k), ifm_req_ready,      v.e_irdy);
            chk($sformatf("v%0d_wrdy", k), wgt_req_ready,      v.e_wrdy);
            chk($sformatf("v%0d_crdy", k), cmp_wr_ready,       v.e_crdy);
            chk($sformatf("v%0d_rv", k),   mem_read_valid,     v.e_rv);
            chk($sformatf("v%0d_wv", k),   mem_write_valid,    v.e_wv);
            chk($sformatf("v%0d_irsp", k), ifm_rsp_valid,      v.e_irsp);
            chk($sformatf("v%0d_wrsp", k), wgt_rsp_valid,      v.e_wrsp);
            chk($sformatf("v%0d_out", k),  outstanding,        v.e_out);
            chk($sformatf("v%0d_err", k),  err_unexpected_rsp, v.e_err);
            if (v.chk_addr)         chk($sformatf("v%0d_addr", k),  mem_addr,       v.e_addr);
            if (v.e_wv)             chk($sformatf("v%0d_wdata", k), mem_write_data, v.e_wdata);
            if (v.e_irsp | v.e_wrsp) chk($sformatf("v%0d_rdata", k), rsp_data,      v.e_rdata);
            @(posedge clk); #2;
        end
        idle_inputs();

        // --- asynchronous reset with two reads in flight
        do_reset();
        ifm_req_valid = 1'b1; ifm_req_addr = 16'h60;
        wgt_req_valid = 1'b1; wgt_req_addr = 16'h70;
        #1;
        chk("ar_irdy0", ifm_req_ready, 1);
        @(posedge clk); #2;
        ifm_req_valid = 1'b0;
        #1;
        chk("ar_wrdy1", wgt_req_ready, 1);
        @(posedge clk); #2;
        wgt_req_valid = 1'b0;
        ifm_req_valid = 1'b1;  // pointer at cmp, 2 outstanding: ifm wins
        #1;
        chk("ar_out2",   outstanding,    2);
        chk("ar_addr70", mem_addr,       16'h70);
        chk("ar_rv",     mem_read_valid, 1);
        chk("ar_irdy2",  ifm_req_ready,  1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async");
        ifm_req_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_out", outstanding, 0);
        // late return from a dropped read
        mem_valid = 1'b1; mem_data = 16'hBEEF;
        @(posedge clk); #2;
        mem_valid = 1'b0;
        #1;
        chk("late_err",  err_unexpected_rsp, 1);
        chk("late_irsp", ifm_rsp_valid,      0);
        chk("late_wrsp", wgt_rsp_valid,      0);
        chk("late_out",  outstanding,        0);
        // pointer must be back at ifm
        ifm_req_valid = 1'b1; wgt_req_valid = 1'b1; cmp_wr_valid = 1'b1;
        #1;
        chk("rel_irdy", ifm_req_ready, 1);
        chk("rel_wrdy", wgt_req_ready, 0);
        chk("rel_crdy", cmp_wr_ready,  0);
        @(posedge clk); #2;
        idle_inputs();
        #1;
        chk("rel_rv",  mem_read_valid, 1);
        chk("rel_err", err_unexpected_rsp, 1);
        @(posedge clk); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
